// File: rtl/pc_ir_unit.sv
// pc_ir_unit: program counter and instruction register for mycpu.
// Ports: clk, rst_n, ps_in, il_in, a_in, imem_* fetch handshake, pc_out, ins_out, ins_valid_out, busy_out.
module pc_ir_unit #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ps_in,
    input  logic              il_in,
    input  logic [15:0]       a_in,
    input  logic [15:0]       imem_rdata_in,
    input  logic              imem_ack_in,
    output logic              imem_req_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [15:0]       ins_out,
    output logic              ins_valid_out,
    output logic              busy_out
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       ins_q;
    logic              valid_q;
    logic [5:0]        br_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (il_in)       state_d = FETCH;
            FETCH: if (imem_ack_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Branch offset is split across the instruction word.
    assign br_off = {ins_q[8:6], ins_q[2:0]};

    always_comb begin
        pc_d = pc_q;
        if (state_q == IDLE) begin
            unique case (ps_in)
                2'b00: pc_d = pc_q;
                2'b01: pc_d = pc_q + 1'b1;
                2'b10: pc_d = pc_q + {{(ADDR_W-6){br_off[5]}}, br_off};
                2'b11: pc_d = a_in[ADDR_W-1:0];
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            ins_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            if (state_q == IDLE && il_in) begin
                // Fetch uses the PC before this edge's update.
                addr_q <= pc_q;
            end
            if (state_q == FETCH && imem_ack_in) begin
                ins_q   <= imem_rdata_in;
                valid_q <= 1'b1;
            end
        end
    end

    assign imem_req_out  = (state_q == FETCH);
    assign busy_out      = (state_q == FETCH);
    assign imem_addr_out = addr_q;
    assign pc_out        = pc_q;
    assign ins_out       = ins_q;
    assign ins_valid_out = valid_q;

endmodule
